// File: rtl/median_seq.sv
// median_seq: median of nine unsigned samples via a shared compare-exchange bubble sort.
module median_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    output logic             BUSY
);
    localparam logic [1:0] LOAD = 2'd0, SORT = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [3:0] cnt, step;
    logic [2:0] pass;
    logic [WIDTH-1:0] r [9];
    logic [WIDTH-1:0] a, b, mn, mx;
    logic last;
    assign a = r[step - 4'd1];
    assign b = r[step];
    assign mn = (a < b) ? a : b;
    assign mx = (a < b) ? b : a;
    // five bubble passes park the five largest at r[4..8], leaving the median in r[4]
    assign last = (step == 4'd8 - {1'b0, pass});
    assign BUSY = (state != LOAD);
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOAD;
            cnt <= '0;
            pass <= '0;
            step <= 4'd1;
            DO <= '0;
            DSO <= 1'b0;
            for (int k = 0; k < 9; k++) r[k] <= '0;
        end else begin
            DSO <= 1'b0;
            case (state)
                LOAD: if (DSI) begin
                    r[0] <= DI;
                    for (int k = 1; k < 9; k++) r[k] <= r[k-1];
                    cnt <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
                    if (cnt == 4'd8) begin
                        state <= SORT;
                        pass <= '0;
                        step <= 4'd1;
                    end
                end
                SORT: begin
                    r[step - 4'd1] <= mn;
                    r[step] <= mx;
                    step <= last ? 4'd1 : step + 4'd1;
                    if (last) pass <= (pass == 3'd4) ? 3'd0 : pass + 3'd1;
                    if (last && pass == 3'd4) state <= DONE;
                end
                DONE: begin
                    DO <= r[4];
                    DSO <= 1'b1;
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_median_seq.sv
// tb_median_seq: directed table plus corner sequences and random sets for median_seq.
module tb_median_seq;
    logic CLK = 1'b0;
    logic RST, DSI, DSO, BUSY;
    logic [7:0] DI, DO;
    int checks = 0, failures = 0, dso_cnt = 0, sets = 0;
    logic [7:0] dso_val;

    typedef struct {
        logic [7:0] d [9];
        logic [7:0] m;
        int gap;
    } vec_t;

    median_seq #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .DI(DI), .DSI(DSI), .DO(DO), .DSO(DSO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (DSO === 1'b1) begin
        dso_cnt++;
        dso_val = DO;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input int gap);
        int n;
        DSI = 1'b0;
        repeat (gap) tick;
        DI = v;
        DSI = 1'b1;
        n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            tick;
            n++;
        end
        if (n == 100) chk("send_timeout", 1, 0);
        tick;
        DSI = 1'b0;
    endtask

    task automatic get_result(input logic [7:0] exp, input string name);
        int n;
        sets++;
        n = 0;
        while (dso_cnt < sets && n < 100) begin
            tick;
            n++;
        end
        chk({name, "_do"}, dso_val, exp);
        chk({name, "_dso_count"}, dso_cnt, sets);
    endtask

    function automatic logic [7:0] med9(input logic [7:0] s [9]);
        logic [7:0] t [9];
        logic [7:0] x;
        t = s;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (t[j] > t[j+1]) begin
                    x = t[j];
                    t[j] = t[j+1];
                    t[j+1] = x;
                end
        return t[4];
    endfunction

    initial begin
        vec_t tbl [9];
        logic [7:0] s [9];
        int lat, busy_bad;
        tbl[0].d = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};         tbl[0].m = 8'd5;   tbl[0].gap = 0;
        tbl[1].d = '{8'd255, 8'd0, 8'd128, 8'd3, 8'd200, 8'd77, 8'd77, 8'd1, 8'd254}; tbl[1].m = 8'd77;  tbl[1].gap = 0;
        tbl[2].d = '{8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};     tbl[2].m = 8'd7;   tbl[2].gap = 1;
        tbl[3].d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};           tbl[3].m = 8'd0;   tbl[3].gap = 0;
        tbl[4].d = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}; tbl[4].m = 8'd255; tbl[4].gap = 2;
        tbl[5].d = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};   tbl[5].m = 8'd0;   tbl[5].gap = 0;
        tbl[6].d = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255}; tbl[6].m = 8'd255; tbl[6].gap = 1;
        tbl[7].d = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};           tbl[7].m = 8'd5;   tbl[7].gap = 0;
        tbl[8].d = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd1, 8'd1, 8'd1, 8'd1, 8'd200}; tbl[8].m = 8'd100; tbl[8].gap = 3;

        RST = 1'b1;
        DSI = 1'b0;
        DI = '0;
        repeat (2) tick;
        chk("reset_do", DO, 0);
        chk("reset_dso", DSO, 0);
        chk("reset_busy", BUSY, 0);
        RST = 1'b0;
        tick;

        // latency and BUSY window
        for (int v = 1; v <= 9; v++) send(8'(v), 0);
        chk("s1_busy_start", BUSY, 1);
        lat = 0;
        busy_bad = 0;
        do begin
            tick;
            lat++;
            if (DSO !== 1'b1 && BUSY !== 1'b1) busy_bad = 1;
        end while (DSO !== 1'b1 && lat < 40);
        chk("s1_latency", lat, 31);
        chk("s1_busy_hold", busy_bad, 0);
        chk("s1_do", DO, 5);
        chk("s1_busy_end", BUSY, 0);
        tick;
        chk("s1_dso_drop", DSO, 0);
        sets++;
        chk("s1_dso_count", dso_cnt, sets);

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) send(tbl[i].d[j], tbl[i].gap);
            get_result(tbl[i].m, $sformatf("tbl%0d", i));
        end

        // DSI held high through the sort must not leak samples into the next set
        for (int v = 1; v <= 9; v++) send(8'(v), 0);
        DI = 8'd200;
        DSI = 1'b1;
        lat = 0;
        do begin
            tick;
            lat++;
        end while (DSO !== 1'b1 && lat < 40);
        DSI = 1'b0;
        chk("s4_do", DO, 5);
        chk("s4_latency", lat, 31);
        sets++;
        for (int v = 9; v >= 1; v--) send(8'(v), 0);
        get_result(8'd5, "s4_next");

        // reset during the sort discards the set
        for (int v = 1; v <= 9; v++) send(8'(v), 0);
        repeat (10) tick;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("s5_do", DO, 0);
        chk("s5_dso", DSO, 0);
        chk("s5_busy", BUSY, 0);
        repeat (40) tick;
        chk("s5_no_dso", dso_cnt, sets);
        for (int v = 1; v <= 9; v++) send(8'(v * 10), 0);
        get_result(8'd50, "s5_set");

        for (int n = 0; n < 1000; n++) begin
            for (int j = 0; j < 9; j++) s[j] = 8'($urandom_range(0, 255));
            for (int j = 0; j < 9; j++) send(s[j], $urandom_range(0, 2));
            get_result(med9(s), $sformatf("rand%0d", n));
        end

        repeat (40) tick;
        chk("final_dso_count", dso_cnt, sets);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/median_seq.md
MEDIAN_SEQ -- requirements
Module: median_seq

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 8, the sample width in bits.
REQ-002 The module SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 DI  input  WIDTH  input sample, unsigned.
REQ-006 DSI  input  1  input strobe; DI is accepted on an edge where DSI=1 and BUSY=0.
REQ-007 DO  output  WIDTH  median result, registered; holds its value until the next result.
REQ-008 DSO  output  1  result strobe, registered; high for exactly one cycle per result.
REQ-009 BUSY  output  1  high while the module is sorting or presenting a result; input is ignored while high.

Function
REQ-010 The module SHALL contain nine WIDTH-bit registers R[0..8] and exactly one compare-exchange unit (MIN/MAX of two operands, unsigned, ties give equal MIN/MAX) shared over all sort steps.
REQ-011 The FSM SHALL have three states: LOAD, SORT and DONE; BUSY SHALL be 1 in SORT and DONE, and 0 in LOAD.
REQ-012 In LOAD, each accepted sample SHALL shift in as R[0] <= DI and R[k] <= R[k-1] for k=1..8, and SHALL increment a load counter CNT (0..8).
REQ-013 In LOAD, an edge with DSI=0 SHALL leave R and CNT unchanged; gaps of any length are legal.
REQ-014 On the edge that accepts the ninth sample (CNT=8), the FSM SHALL go to SORT with PASS=0, STEP=1 and CNT=0.
REQ-015 SORT SHALL perform one compare-exchange per cycle: operands A=R[STEP-1] and B=R[STEP]; then R[STEP-1] <= MIN and R[STEP] <= MAX.
REQ-016 Pass PASS (0..4) SHALL run STEP=1..8-PASS. After the last step of a pass, PASS SHALL increment and STEP SHALL reset to 1.
REQ-017 SORT SHALL last exactly 8+7+6+5+4 = 30 cycles; on the edge that completes PASS=4, STEP=4, the FSM SHALL go to DONE.
REQ-018 After SORT, R[4] SHALL hold the median (5th smallest) of the nine samples, duplicates included.
REQ-019 In DONE, the next edge SHALL load DO <= R[4], set DSO <= 1 and move the FSM to LOAD.
REQ-020 On the edge after DSO rises, DSO SHALL return to 0, whatever the DSI value.
REQ-021 Latency: if the ninth sample is accepted at edge N, DO/DSO SHALL update at edge N+31. A new first sample MAY be accepted at edge N+31.
REQ-022 DSI=1 while BUSY=1 SHALL be ignored, with no effect on R, CNT or the result.
REQ-023 R contents left over from a finished sort SHALL be shifted out by the next nine samples; no clear is needed between sets.

Reset
REQ-024 While RST=1 at an edge, the module SHALL set state=LOAD, CNT=0, PASS=0, STEP=1, R[0..8]=0, DO=0, DSO=0 and BUSY=0.
REQ-025 RST SHALL have priority over DSI and over any state transition, including reset in mid-LOAD, mid-SORT or DONE; a partial set SHALL be discarded.

Verification
REQ-026 Scenario 1: DI=1..9 on nine consecutive edges with DSI=1 -> DSO=1 for one cycle at edge N+31, DO=5; BUSY=1 from edge N to edge N+31.
REQ-027 Scenario 2: DI=9,8,...,1, then DI=255,0,128,3,200,77,77,1,254 back-to-back -> DO=5, then DO=77; the second set loads starting at edge N+31.
REQ-028 Scenario 3: DI=7,7,7,0,0,0,255,255,255 with DSI toggling 1,0,1,0,... -> DO=7; CNT does not advance on DSI=0 edges.
REQ-029 Scenario 4: load 1..9, hold DSI=1 with DI=200 throughout SORT -> DO=5; no extra samples are captured.
REQ-030 Scenario 5: RST=1 for one edge at SORT cycle 10, then load 10,20,...,90 -> no DSO from the aborted set, DO=50; DO=0 is read right after the reset.
REQ-031 Scenario 6: 1000 random 9-sample sets with random DSI gaps, checked against a software sort's element [4] -> every DO matches, and exactly one DSO per set.
